// File: rtl/inst_mem_responder.sv
// ---------------------------------------------------------------------------
// inst_mem_responder
//
// Purpose:
//   Instruction memory model that answers fetch requests with a fixed,
//   parameterised latency. It holds one outstanding request at a time:
//   accept in IDLE, count down LATENCY wait cycles in WAIT, then hold the
//   fetched word in RESP until the fetch stage takes it.
//   The array can be preloaded at any time through the Init_* port.
//
// Parameters:
//   DEPTH   - number of 32-bit words; a power of two, at least 2.
//   LATENCY - wait cycles between accept and response, 0..15.
//
// Ports:
//   clk            - single clock; all state changes on its rising edge
//   rst            - asynchronous, active-high reset
//   PC             - request byte address
//   Inst_Req_Valid - request present
//   Inst_Req_Ready - responder can accept (high only in IDLE)
//   Instruction    - returned word, held stable while Inst_Valid is high
//   Inst_Valid     - response present (high only in RESP)
//   Inst_Ready     - fetch stage takes the response
//   Init_WE        - preload write enable
//   Init_Addr      - preload byte address
//   Init_Data      - preload data
//   Misalign_Err   - sticky: an accepted PC had PC[1:0] != 0
//   Resp_Cnt       - number of completed responses (wraps)
//   o_dbg_state    - one-hot FSM state {RESP, WAIT, IDLE}
//
// Handshake rule (both channels):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The producer keeps valid (and its payload) stable until that edge; the
//   responder never withdraws Inst_Valid without a completed handshake.
// ---------------------------------------------------------------------------
module inst_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic        Init_WE,
  input  logic [31:0] Init_Addr,
  input  logic [31:0] Init_Data,
  output logic        Misalign_Err,
  output logic [31:0] Resp_Cnt,
  output logic [2:0]  o_dbg_state
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  LAT_VAL = 4'(LATENCY);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_WAIT = 3'b010,
    S_RESP = 3'b100
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_word;
  logic [31:0]   r_instruction;
  logic          r_valid;
  logic          r_req_ready;
  logic          r_misalign;
  logic [31:0]   r_resp_cnt;

  // Not reset: contents persist across rst.
  logic [31:0]   r_mem [DEPTH];

  logic [AW-1:0] w_req_word;
  logic [AW-1:0] w_init_word;
  logic          w_unused_addr_bits;

  // Upper address bits are dropped so addresses wrap modulo DEPTH*4.
  assign w_req_word  = PC[AW+1:2];
  assign w_init_word = Init_Addr[AW+1:2];
  assign w_unused_addr_bits = ^{PC[31:AW+2], Init_Addr[31:AW+2], Init_Addr[1:0]};

  // Preload port. The FSM reads r_mem with a non-blocking capture on the
  // same edge, so a simultaneous write to the captured word is seen only
  // by later fetches (read-before-write).
  always_ff @(posedge clk) begin
    if (Init_WE) begin
      r_mem[w_init_word] <= Init_Data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_word        <= '0;
      r_instruction <= 32'd0;
      r_valid       <= 1'b0;
      r_req_ready   <= 1'b1;
      r_misalign    <= 1'b0;
      r_resp_cnt    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Inst_Req_Valid) begin
            r_word      <= w_req_word;
            r_cnt       <= LAT_VAL;
            r_req_ready <= 1'b0;
            r_state     <= S_WAIT;
            if (PC[1:0] != 2'b00) begin
              r_misalign <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_instruction <= r_mem[r_word];
            r_valid       <= 1'b1;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          // Instruction is only loaded on the WAIT->RESP edge, so later
          // preload writes cannot disturb the held word.
          if (Inst_Ready) begin
            r_valid     <= 1'b0;
            r_req_ready <= 1'b1;
            r_resp_cnt  <= r_resp_cnt + 32'd1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_valid     <= 1'b0;
          r_req_ready <= 1'b1;
          r_cnt       <= 4'd0;
        end
      endcase
    end
  end

  assign Inst_Req_Ready = r_req_ready;
  assign Instruction    = r_instruction;
  assign Inst_Valid     = r_valid;
  assign Misalign_Err   = r_misalign;
  assign Resp_Cnt       = r_resp_cnt;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_inst_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_responder
//
// Two responders share clock, reset, PC, Inst_Ready and the preload port:
//   dut_a : DEPTH=1024, LATENCY=2
//   dut_b : DEPTH=1024, LATENCY=0
// Each has its own Inst_Req_Valid so only one of them runs a fetch at a time.
// Inputs change on falling edges; outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        req_valid_a, req_valid_b;
  logic        inst_ready;
  logic        init_we;
  logic [31:0] init_addr, init_data;

  logic        req_ready_a, valid_a, mis_a;
  logic [31:0] inst_a, cnt_a;
  logic [2:0]  dbg_a;
  logic        req_ready_b, valid_b, mis_b;
  logic [31:0] inst_b, cnt_b;
  logic [2:0]  dbg_b;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cnt_a = 32'd0;
  logic [31:0] exp_cnt_b = 32'd0;

  always #5 clk = ~clk;

  inst_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .PC(pc),
    .Inst_Req_Valid(req_valid_a), .Inst_Req_Ready(req_ready_a),
    .Instruction(inst_a), .Inst_Valid(valid_a), .Inst_Ready(inst_ready),
    .Init_WE(init_we), .Init_Addr(init_addr), .Init_Data(init_data),
    .Misalign_Err(mis_a), .Resp_Cnt(cnt_a), .o_dbg_state(dbg_a)
  );

  inst_mem_responder #(.DEPTH(1024), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .PC(pc),
    .Inst_Req_Valid(req_valid_b), .Inst_Req_Ready(req_ready_b),
    .Instruction(inst_b), .Inst_Valid(valid_b), .Inst_Ready(inst_ready),
    .Init_WE(init_we), .Init_Addr(init_addr), .Init_Data(init_data),
    .Misalign_Err(mis_b), .Resp_Cnt(cnt_b), .o_dbg_state(dbg_b)
  );

  // ---------------- driver tasks (called at a falling edge) ----------------

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    init_addr = addr;
    init_data = data;
    init_we   = 1'b1;
    @(negedge clk);
    init_we   = 1'b0;
  endtask

  // One-cycle request; the target is in IDLE, so the next edge accepts.
  // Returns at the falling edge after the accept edge.
  task automatic issue(input bit sel_b, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    if (sel_b) req_valid_b = 1'b1;
    else       req_valid_a = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  // Counts rising edges until Inst_Valid is seen, bounded at 32.
  task automatic wait_valid(input bit sel_b, output int cycles);
    cycles = 0;
    while (!(sel_b ? valid_b : valid_a) && cycles < 32) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready_a !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready_a); end
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    checks++; if (inst_a !== 32'd0) begin failures++; $display("FAIL reset_inst got=%h exp=00000000", inst_a); end
    checks++; if (mis_a !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", mis_a); end
    checks++; if (cnt_a !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=00000000", cnt_a); end
    checks++; if (dbg_a !== 3'b001) begin failures++; $display("FAIL reset_state got=%b exp=001", dbg_a); end
    checks++; if (req_ready_b !== 1'b1) begin failures++; $display("FAIL reset_req_ready_b got=%b exp=1", req_ready_b); end
    // Preload while still in reset: the array is not under reset control.
    write_word(32'h0000_0000, 32'h0000_0013);
    write_word(32'h0000_0004, 32'hDEAD_BEEF);
    write_word(32'h0000_0010, 32'h1111_1111);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    logic [31:0] exp_w;
    inst_ready = 1'b1;
    // Issued on the same falling edge rst dropped: first edge accepts.
    issue(1'b0, 32'h0, 32'h0000_0013);
    checks++; if (dbg_a !== 3'b010) begin failures++; $display("FAIL basic_wait_state got=%b exp=010", dbg_a); end
    wait_valid(1'b0, cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", cyc); end
    exp_w = exp_q.pop_front();
    checks++; if (inst_a !== exp_w) begin failures++; $display("FAIL basic_data got=%h exp=%h", inst_a, exp_w); end
    @(negedge clk);
    exp_cnt_a++;
    checks++; if (cnt_a !== exp_cnt_a) begin failures++; $display("FAIL basic_cnt got=%h exp=%h", cnt_a, exp_cnt_a); end
    checks++; if (req_ready_a !== 1'b1 || valid_a !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b%b exp=10", req_ready_a, valid_a); end
    // Inst_Ready high in IDLE must do nothing.
    repeat (3) @(negedge clk);
    checks++; if (cnt_a !== exp_cnt_a || valid_a !== 1'b0) begin failures++; $display("FAIL idle_ready_noop got=%h/%b exp=%h/0", cnt_a, valid_a, exp_cnt_a); end
  endtask

  task automatic test_hold();
    int cyc;
    logic [31:0] exp_w;
    inst_ready = 1'b0;
    issue(1'b0, 32'h4, 32'hDEAD_BEEF);
    wait_valid(1'b0, cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL hold_latency got=%0d exp=3", cyc); end
    exp_w = exp_q.pop_front();
    checks++; if (inst_a !== exp_w) begin failures++; $display("FAIL hold_data got=%h exp=%h", inst_a, exp_w); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || inst_a !== exp_w) begin
        failures++; $display("FAIL hold_stable cycle=%0d got=%b/%h exp=1/%h", i, valid_a, inst_a, exp_w);
      end
    end
    inst_ready = 1'b1;
    @(negedge clk);
    exp_cnt_a++;
    checks++; if (valid_a !== 1'b0 || req_ready_a !== 1'b1) begin failures++; $display("FAIL hold_release got=%b%b exp=01", valid_a, req_ready_a); end
    checks++; if (cnt_a !== exp_cnt_a) begin failures++; $display("FAIL hold_cnt got=%h exp=%h", cnt_a, exp_cnt_a); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] exp_w;
    inst_ready  = 1'b1;
    pc          = 32'h0;
    req_valid_a = 1'b1;
    exp_q.push_back(32'h0000_0013);
    exp_q.push_back(32'h0000_0013);
    @(negedge clk);
    wait_valid(1'b0, cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=3", cyc); end
    exp_w = exp_q.pop_front();
    checks++; if (inst_a !== exp_w) begin failures++; $display("FAIL b2b_first_data got=%h exp=%h", inst_a, exp_w); end
    @(negedge clk);
    checks++; if (req_ready_a !== 1'b1 || valid_a !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b%b exp=10", req_ready_a, valid_a); end
    // One IDLE cycle, then accept, then LATENCY+1.
    wait_valid(1'b0, cyc);
    req_valid_a = 1'b0;
    checks++; if (cyc != 4) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=4", cyc); end
    exp_w = exp_q.pop_front();
    checks++; if (inst_a !== exp_w) begin failures++; $display("FAIL b2b_second_data got=%h exp=%h", inst_a, exp_w); end
    @(negedge clk);
    exp_cnt_a = exp_cnt_a + 32'd2;
    checks++; if (cnt_a !== exp_cnt_a) begin failures++; $display("FAIL b2b_cnt got=%h exp=%h", cnt_a, exp_cnt_a); end
  endtask

  task automatic test_wrap_misalign();
    int cyc;
    logic [31:0] exp_w;
    inst_ready = 1'b1;
    issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
    wait_valid(1'b1, cyc);
    checks++; if (cyc != 1) begin failures++; $display("FAIL wrap_latency got=%0d exp=1", cyc); end
    exp_w = exp_q.pop_front();
    checks++; if (inst_b !== exp_w) begin failures++; $display("FAIL wrap_data got=%h exp=%h", inst_b, exp_w); end
    @(negedge clk);
    exp_cnt_b++;
    checks++; if (mis_b !== 1'b0) begin failures++; $display("FAIL aligned_no_err got=%b exp=0", mis_b); end
    issue(1'b1, 32'h0000_0006, 32'hDEAD_BEEF);
    checks++; if (mis_b !== 1'b1) begin failures++; $display("FAIL misalign_set got=%b exp=1", mis_b); end
    wait_valid(1'b1, cyc);
    checks++; if (cyc != 1) begin failures++; $display("FAIL misalign_latency got=%0d exp=1", cyc); end
    exp_w = exp_q.pop_front();
    checks++; if (inst_b !== exp_w) begin failures++; $display("FAIL misalign_data got=%h exp=%h", inst_b, exp_w); end
    @(negedge clk);
    exp_cnt_b++;
    checks++; if (mis_b !== 1'b1) begin failures++; $display("FAIL misalign_sticky got=%b exp=1", mis_b); end
    checks++; if (cnt_b !== exp_cnt_b) begin failures++; $display("FAIL b_cnt got=%h exp=%h", cnt_b, exp_cnt_b); end
    checks++; if (mis_a !== 1'b0) begin failures++; $display("FAIL a_no_misalign got=%b exp=0", mis_a); end
  endtask

  task automatic test_read_before_write();
    int cyc;
    logic [31:0] exp_w;
    inst_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h1111_1111);      // accept edge E0
    @(negedge clk);                           // after E1
    @(negedge clk);                           // after E2; E3 is the capture edge
    init_addr = 32'h10; init_data = 32'h2222_2222; init_we = 1'b1;
    @(negedge clk);
    init_we = 1'b0;
    exp_w = exp_q.pop_front();
    checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL rbw_valid got=%b exp=1", valid_a); end
    checks++; if (inst_a !== exp_w) begin failures++; $display("FAIL rbw_old_data got=%h exp=%h", inst_a, exp_w); end
    // A further write during RESP must leave the held word alone.
    write_word(32'h10, 32'h2222_2222);
    checks++; if (inst_a !== exp_w || valid_a !== 1'b1) begin failures++; $display("FAIL resp_write_hold got=%h exp=%h", inst_a, exp_w); end
    inst_ready = 1'b1;
    @(negedge clk);
    exp_cnt_a++;
    issue(1'b0, 32'h10, 32'h2222_2222);
    wait_valid(1'b0, cyc);
    checks++; if (cyc != 3) begin failures++; $display("FAIL rbw_refetch_latency got=%0d exp=3", cyc); end
    exp_w = exp_q.pop_front();
    checks++; if (inst_a !== exp_w) begin failures++; $display("FAIL rbw_new_data got=%h exp=%h", inst_a, exp_w); end
    @(negedge clk);
    exp_cnt_a++;
    checks++; if (cnt_a !== exp_cnt_a) begin failures++; $display("FAIL rbw_cnt got=%h exp=%h", cnt_a, exp_cnt_a); end
  endtask

  task automatic test_async_reset();
    int cyc;
    logic seen;
    logic [31:0] exp_w;
    inst_ready = 1'b1;
    issue(1'b0, 32'h0, 32'h0000_0013);
    checks++; if (dbg_a !== 3'b010) begin failures++; $display("FAIL arst_in_wait got=%b exp=010", dbg_a); end
    #2 rst = 1'b1;
    #1;
    // No rising edge since rst rose: these must come from the async path.
    checks++; if (req_ready_a !== 1'b1 || valid_a !== 1'b0) begin failures++; $display("FAIL arst_outputs got=%b%b exp=10", req_ready_a, valid_a); end
    checks++; if (cnt_a !== 32'd0) begin failures++; $display("FAIL arst_cnt got=%h exp=00000000", cnt_a); end
    checks++; if (dbg_a !== 3'b001) begin failures++; $display("FAIL arst_state got=%b exp=001", dbg_a); end
    checks++; if (mis_b !== 1'b0) begin failures++; $display("FAIL arst_misalign_clear got=%b exp=0", mis_b); end
    exp_q.delete();
    exp_cnt_a = 32'd0;
    exp_cnt_b = 32'd0;
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (valid_a) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || cnt_a !== 32'd0) begin failures++; $display("FAIL arst_no_response got=%b/%h exp=0/00000000", seen, cnt_a); end
    // Memory survives reset.
    issue(1'b0, 32'h0, 32'h0000_0013);
    wait_valid(1'b0, cyc);
    exp_w = exp_q.pop_front();
    checks++; if (cyc != 3 || inst_a !== exp_w) begin failures++; $display("FAIL mem_persist got=%0d/%h exp=3/%h", cyc, inst_a, exp_w); end
    @(negedge clk);
    exp_cnt_a++;
  endtask

  task automatic test_cnt_wrap();
    int cyc;
    logic [31:0] exp_w;
    force dut_a.r_resp_cnt = 32'hFFFF_FFFF;
    #1 release dut_a.r_resp_cnt;
    exp_cnt_a = 32'hFFFF_FFFF;
    checks++; if (cnt_a !== exp_cnt_a) begin failures++; $display("FAIL cnt_preset got=%h exp=%h", cnt_a, exp_cnt_a); end
    inst_ready = 1'b1;
    issue(1'b0, 32'h4, 32'hDEAD_BEEF);
    wait_valid(1'b0, cyc);
    exp_w = exp_q.pop_front();
    checks++; if (cyc != 3 || inst_a !== exp_w) begin failures++; $display("FAIL cnt_wrap_resp got=%0d/%h exp=3/%h", cyc, inst_a, exp_w); end
    @(negedge clk);
    exp_cnt_a = exp_cnt_a + 32'd1;
    checks++; if (cnt_a !== exp_cnt_a) begin failures++; $display("FAIL cnt_wrap got=%h exp=%h", cnt_a, exp_cnt_a); end
  endtask

  initial begin
    rst = 1'b1; pc = 32'd0; req_valid_a = 1'b0; req_valid_b = 1'b0;
    inst_ready = 1'b0; init_we = 1'b0; init_addr = 32'd0; init_data = 32'd0;
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_wrap_misalign();
    test_read_before_write();
    test_async_reset();
    test_cnt_wrap();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 Parameter: DEPTH, default 1024, number of 32-bit instruction words; a power of two, at least 2.
REQ-002 Parameter: LATENCY, default 2, wait cycles between request accept and response; range 0..15.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: PC  input  32  request byte address from fetch stage.
REQ-006 Port: Inst_Req_Valid  input  1  fetch stage presents a request.
REQ-007 Port: Inst_Req_Ready  output  1  responder can accept a request.
REQ-008 Port: Instruction  output  32  returned instruction word.
REQ-009 Port: Inst_Valid  output  1  Instruction is valid.
REQ-010 Port: Inst_Ready  input  1  fetch stage accepts the response.
REQ-011 Port: Init_WE  input  1  preload write enable.
REQ-012 Port: Init_Addr  input  32  preload byte address.
REQ-013 Port: Init_Data  input  32  preload data.
REQ-014 Port: Misalign_Err  output  1  sticky flag: an accepted PC had PC[1:0] != 0.
REQ-015 Port: Resp_Cnt  output  32  count of completed responses.

Function
REQ-016 FSM states are IDLE, WAIT and RESP, one-hot encoded.
REQ-017 IDLE: Inst_Req_Ready=1, Inst_Valid=0.
REQ-018 WAIT: Inst_Req_Ready=0, Inst_Valid=0.
REQ-019 RESP: Inst_Req_Ready=0, Inst_Valid=1.
REQ-020 Accept happens on an edge where state=IDLE and Inst_Req_Valid=1: latch PC, load the wait counter with LATENCY, go to WAIT.
REQ-021 In WAIT, a nonzero counter decrements each edge; at counter=0 the edge goes to RESP and captures mem[word index] into the Instruction register.
REQ-022 Word index = PC[log2(DEPTH)+1:2]: PC[1:0] ignored, upper bits ignored, so addresses wrap modulo DEPTH*4.
REQ-023 Inst_Valid rises exactly LATENCY+1 cycles after the accept edge.
REQ-024 Instruction and Inst_Valid hold stable in RESP until an edge with Inst_Ready=1.
REQ-025 That edge completes the response: go to IDLE, increment Resp_Cnt (wraps 0xFFFFFFFF -> 0).
REQ-026 Inst_Ready=1 while in IDLE or WAIT has no effect; the responder never drops Inst_Valid without a handshake.
REQ-027 Back-to-back requests: earliest next accept is the edge after the completing edge (one IDLE cycle minimum).
REQ-028 Inst_Req_Valid deasserted before accept: no state change.
REQ-029 Init_WE=1 writes Init_Data to mem[Init_Addr word index] on the edge, in any state.
REQ-030 Write and RESP capture to the same word on the same edge: the capture returns the old data (read-before-write); the write still completes.
REQ-031 A write during RESP does not alter the held Instruction.
REQ-032 Misalign_Err sets on an accept with PC[1:0] != 0; it clears only on reset.
REQ-033 Instruction from the array is unaffected by a misaligned PC (same word as aligned).

Reset
REQ-034 rst=1 forces immediately, regardless of clk: state=IDLE, counter=0, Instruction=0, Inst_Valid=0, Inst_Req_Ready=1, Misalign_Err=0, Resp_Cnt=0.
REQ-035 Memory contents are not reset; they persist across rst.
REQ-036 Reset mid-WAIT or mid-RESP abandons the transaction, produces no response, and does not increment Resp_Cnt.
REQ-037 The first accept is possible on the first rising edge after rst deasserts.

Verification
REQ-038 LATENCY=2; preload word 0=0x00000013; PC=0, Valid 1 cycle, Inst_Ready=1 -> Inst_Valid high exactly 3 cycles after accept with 0x00000013; Resp_Cnt=1.
REQ-039 Inst_Ready held 0 for 5 cycles in RESP -> Instruction/Inst_Valid stable; the sixth edge with Inst_Ready=1 completes; Inst_Req_Ready=1 the cycle after.
REQ-040 LATENCY=0, DEPTH=1024; PC=0x00001004 with word 1=0xDEADBEEF -> 0xDEADBEEF one cycle after accept (wrap); PC=0x6 -> word 1 returned and Misalign_Err=1.
REQ-041 Init_WE to word 4 (0x11111111 -> 0x22222222) on the RESP-capture edge for PC=0x10 -> 0x11111111 returned; the next fetch of 0x10 returns 0x22222222.
REQ-042 rst asserted asynchronously mid-WAIT -> Inst_Req_Ready=1 and Inst_Valid=0 before the next edge; Resp_Cnt=0; no response ever issued.
REQ-043 Resp_Cnt forced to 0xFFFFFFFF, one transaction -> Resp_Cnt=0.
